// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage RAW forwarding from EX/MEM and MEM/WB.
// It drives the ALU operands directly and detects load-use hazards, inserting one bubble.
module id_ex_operand_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [DATA_WIDTH-1:0] id_pc,
  input  logic [DATA_WIDTH-1:0] id_rs1_data,
  input  logic [DATA_WIDTH-1:0] id_rs2_data,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic [REG_AW-1:0]     id_rs1,
  input  logic [REG_AW-1:0]     id_rs2,
  input  logic [REG_AW-1:0]     id_rd,
  input  logic [3:0]            id_alu_op,
  input  logic                  id_alu_src,
  input  logic                  id_use_pc,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic [REG_AW-1:0]     exmem_rd,
  input  logic                  exmem_reg_write,
  input  logic [DATA_WIDTH-1:0] exmem_result,
  input  logic [REG_AW-1:0]     memwb_rd,
  input  logic                  memwb_reg_write,
  input  logic [DATA_WIDTH-1:0] memwb_result,
  output logic                  load_use_stall,
  output logic [DATA_WIDTH-1:0] alu_in_1,
  output logic [DATA_WIDTH-1:0] alu_in_2,
  output logic [3:0]            alu_op,
  output logic                  ex_valid,
  output logic [DATA_WIDTH-1:0] ex_pc,
  output logic [REG_AW-1:0]     ex_rd,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic [DATA_WIDTH-1:0] ex_store_data
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] rs1_data_q;
  logic [DATA_WIDTH-1:0] rs2_data_q;
  logic [DATA_WIDTH-1:0] imm_q;
  logic [REG_AW-1:0]     rs1_q;
  logic [REG_AW-1:0]     rs2_q;
  logic [REG_AW-1:0]     rd_q;
  logic [3:0]            alu_op_q;
  logic                  alu_src_q;
  logic                  use_pc_q;
  logic                  reg_write_q;
  logic                  mem_read_q;
  logic                  mem_write_q;

  logic                  hazard;
  logic [DATA_WIDTH-1:0] fwd_rs1;
  logic [DATA_WIDTH-1:0] fwd_rs2;

  // A bubble and a reset load the same all-zero contents.
  task automatic clear_regs();
    valid_q     <= 1'b0;
    pc_q        <= '0;
    rs1_data_q  <= '0;
    rs2_data_q  <= '0;
    imm_q       <= '0;
    rs1_q       <= '0;
    rs2_q       <= '0;
    rd_q        <= '0;
    alu_op_q    <= 4'h0;
    alu_src_q   <= 1'b0;
    use_pc_q    <= 1'b0;
    reg_write_q <= 1'b0;
    mem_read_q  <= 1'b0;
    mem_write_q <= 1'b0;
  endtask

  always_ff @(posedge clk) begin
    if (reset || flush || (!stall && load_use_stall)) begin
      clear_regs();
    end else if (!stall) begin
      valid_q     <= id_valid;
      pc_q        <= id_pc;
      rs1_data_q  <= id_rs1_data;
      rs2_data_q  <= id_rs2_data;
      imm_q       <= id_imm;
      rs1_q       <= id_rs1;
      rs2_q       <= id_rs2;
      rd_q        <= id_rd;
      alu_op_q    <= id_alu_op;
      alu_src_q   <= id_alu_src;
      use_pc_q    <= id_use_pc;
      reg_write_q <= id_valid & id_reg_write;
      mem_read_q  <= id_valid & id_mem_read;
      mem_write_q <= id_valid & id_mem_write;
    end
  end

  assign hazard = valid_q & mem_read_q & (rd_q != '0) & id_valid &
                  (((id_rs1 == rd_q) & !id_use_pc) |
                   ((id_rs2 == rd_q) & (!id_alu_src | id_mem_write)));
  assign load_use_stall = hazard & !stall & !flush;

  // EX/MEM is the younger producer, so it is checked first; x0 never matches.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs1_q)
      fwd_rs1 = exmem_result;
    else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs1_q)
      fwd_rs1 = memwb_result;
  end

  always_comb begin
    fwd_rs2 = rs2_data_q;
    if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs2_q)
      fwd_rs2 = exmem_result;
    else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs2_q)
      fwd_rs2 = memwb_result;
  end

  assign alu_in_1      = use_pc_q  ? pc_q  : fwd_rs1;
  assign alu_in_2      = alu_src_q ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign alu_op        = alu_op_q;
  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = valid_q & reg_write_q;
  assign ex_mem_read   = valid_q & mem_read_q;
  assign ex_mem_write  = valid_q & mem_write_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: directed vectors push expectations,
// and a negedge monitor pops and compares them against the EX-stage outputs.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_op;
  logic        id_alu_src, id_use_pc, id_reg_write, id_mem_read, id_mem_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_reg_write, memwb_reg_write;
  logic [31:0] exmem_result, memwb_result;
  logic        load_use_stall;
  logic [31:0] alu_in_1, alu_in_2, ex_pc, ex_store_data;
  logic [3:0]  alu_op;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [4:0]  ex_rd;

  id_ex_operand_stage #(.DATA_WIDTH(32), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_use_pc(id_use_pc),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .exmem_rd(exmem_rd),
    .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
    .memwb_result(memwb_result), .load_use_stall(load_use_stall),
    .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .alu_op(alu_op),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  m;
    logic        v;
    logic        lus;
    logic [31:0] a1, a2;
    logic [3:0]  op;
    logic [31:0] pc, sd;
    logic [7:0]  ctl;
  } exp_t;

  // mask bits: 0 valid, 1 load_use_stall, 2 alu_in_1, 3 alu_in_2, 4 alu_op, 5 pc, 6 store, 7 ctl
  localparam logic [7:0] M_ALL = 8'hFF;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(string n, string f, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s.%s got %h want %h", n, f, got, want);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.m[0]) chk(e.name, "ex_valid", {31'b0, ex_valid}, {31'b0, e.v});
        if (e.m[1]) chk(e.name, "load_use_stall", {31'b0, load_use_stall}, {31'b0, e.lus});
        if (e.m[2]) chk(e.name, "alu_in_1", alu_in_1, e.a1);
        if (e.m[3]) chk(e.name, "alu_in_2", alu_in_2, e.a2);
        if (e.m[4]) chk(e.name, "alu_op", {28'b0, alu_op}, {28'b0, e.op});
        if (e.m[5]) chk(e.name, "ex_pc", ex_pc, e.pc);
        if (e.m[6]) chk(e.name, "ex_store_data", ex_store_data, e.sd);
        if (e.m[7]) chk(e.name, "ctl", {24'b0, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write},
                        {24'b0, e.ctl});
      end
    end
  end

  task automatic push(string n, logic [7:0] m, logic v, logic lus, logic [31:0] a1, logic [31:0] a2,
                      logic [3:0] op, logic [31:0] pc, logic [31:0] sd,
                      logic [4:0] rd, logic rw, logic mr, logic mw);
    exp_t e;
    e.name = n; e.m = m; e.v = v; e.lus = lus; e.a1 = a1; e.a2 = a2;
    e.op = op; e.pc = pc; e.sd = sd; e.ctl = {rd, rw, mr, mw};
    q.push_back(e);
  endtask

  task automatic id_set(logic v, logic [31:0] pc, logic [31:0] r1d, logic [31:0] r2d,
                        logic [31:0] imm, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                        logic [3:0] op, logic src, logic upc, logic rw, logic mr, logic mw);
    id_valid = v; id_pc = pc; id_rs1_data = r1d; id_rs2_data = r2d; id_imm = imm;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_alu_op = op; id_alu_src = src;
    id_use_pc = upc; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic id_idle();
    id_set(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_fwd(logic [4:0] xrd, logic xrw, logic [31:0] xres,
                         logic [4:0] wrd, logic wrw, logic [31:0] wres);
    exmem_rd = xrd; exmem_reg_write = xrw; exmem_result = xres;
    memwb_rd = wrd; memwb_reg_write = wrw; memwb_result = wres;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with random ID and forwarding inputs
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    id_set(1'b1, $urandom, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom),
           5'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b1, 1'($urandom));
    set_fwd(5'($urandom), 1'b1, $urandom, 5'($urandom), 1'b1, $urandom);
    step();
    step();
    push("reset", M_ALL, 0, 0, 0, 0, 4'h0, 0, 0, 5'd0, 0, 0, 0);
    reset = 1'b0;
    id_idle();
    set_fwd(0, 0, 0, 0, 0, 0);
    step();

    // ADD x5,x1,x2 then ADD x6,x5,x5 with EX/MEM forwarding
    id_set(1, 32'h40, 32'h3, 32'h4, 32'h0, 5'd1, 5'd2, 5'd5, 4'h0, 0, 0, 1, 0, 0);
    step();
    id_set(1, 32'h44, 32'hBAD1, 32'hBAD2, 32'h0, 5'd5, 5'd5, 5'd6, 4'h0, 0, 0, 1, 0, 0);
    push("add_x5", M_ALL, 1, 0, 32'h3, 32'h4, 4'h0, 32'h40, 32'h4, 5'd5, 1, 0, 0);
    step();
    set_fwd(5'd5, 1, 32'h10, 0, 0, 0);
    id_idle();
    push("fwd_exmem", M_ALL, 1, 0, 32'h10, 32'h10, 4'h0, 32'h44, 32'h10, 5'd6, 1, 0, 0);

    // EX/MEM priority over MEM/WB, then MEM/WB alone
    id_set(1, 32'h48, 32'h77, 32'h33, 32'h44, 5'd7, 5'd3, 5'd10, 4'h2, 1, 0, 1, 0, 0);
    step();
    set_fwd(5'd7, 1, 32'hAAAA_0000, 5'd7, 1, 32'h0000_5555);
    id_set(1, 32'h4C, 32'h77, 32'h33, 32'h0, 5'd7, 5'd3, 5'd11, 4'h2, 0, 0, 1, 0, 0);
    push("fwd_prio", 8'h5D, 1, 0, 32'hAAAA_0000, 32'h44, 4'h2, 0, 32'h33, 0, 0, 0, 0);
    step();
    set_fwd(5'd7, 0, 32'hAAAA_0000, 5'd7, 1, 32'h0000_5555);
    id_idle();
    push("fwd_memwb", 8'h4D, 1, 0, 32'h5555, 32'h33, 0, 0, 32'h33, 0, 0, 0, 0);

    // LW x8 then ADD x9,x8,x1: one bubble
    id_set(1, 32'h50, 32'h100, 32'h0, 32'h4, 5'd1, 5'd0, 5'd8, 4'h0, 1, 0, 1, 1, 0);
    step();
    set_fwd(0, 0, 0, 0, 0, 0);
    id_set(1, 32'h54, 32'h88, 32'h11, 32'h0, 5'd8, 5'd1, 5'd9, 4'h0, 0, 0, 1, 0, 0);
    push("lu_detect", M_ALL, 1, 1, 32'h100, 32'h4, 4'h0, 32'h50, 32'h0, 5'd8, 1, 1, 0);
    step();
    set_fwd(5'd8, 1, 32'h1234, 0, 0, 0);
    push("lu_bubble", M_ALL, 0, 0, 0, 0, 4'h0, 0, 0, 5'd0, 0, 0, 0);
    step();
    set_fwd(0, 0, 0, 5'd8, 1, 32'h5678);
    id_idle();
    push("lu_resume", M_ALL, 1, 0, 32'h5678, 32'h11, 4'h0, 32'h54, 32'h11, 5'd9, 1, 0, 0);

    // Store data hazard on rs2 even though alu_src selects imm
    id_set(1, 32'h58, 32'h100, 32'h0, 32'h4, 5'd1, 5'd0, 5'd8, 4'h0, 1, 0, 1, 1, 0);
    step();
    set_fwd(0, 0, 0, 0, 0, 0);
    id_set(1, 32'h5C, 32'h22, 32'h99, 32'h8, 5'd2, 5'd8, 5'd0, 4'h0, 1, 0, 0, 0, 1);
    push("lu_store", 8'h03, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    id_idle();
    push("lu_store_bubble", 8'h01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // x0 is never forwarded
    id_set(1, 32'h60, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd1, 4'h1, 0, 0, 1, 0, 0);
    step();
    set_fwd(5'd0, 1, 32'hDEAD_BEEF, 5'd0, 1, 32'hCAFE_F00D);
    id_idle();
    push("x0_fwd", 8'h4D, 1, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0);

    // Stall hold (with a masked load-use), then flush winning over stall
    id_set(1, 32'h100, 32'h1, 32'h2, 32'h8, 5'd1, 5'd2, 5'd12, 4'h5, 1, 0, 1, 1, 0);
    step();
    set_fwd(0, 0, 0, 0, 0, 0);
    stall = 1'b1;
    id_set(1, 32'h200, 32'h0, 32'h0, 32'h0, 5'd12, 5'd0, 5'd13, 4'h9, 0, 0, 1, 0, 0);
    push("stall_lus", 8'h33, 1, 0, 0, 0, 4'h5, 32'h100, 0, 0, 0, 0, 0);
    step();
    push("stall_hold", M_ALL, 1, 0, 32'h1, 32'h8, 4'h5, 32'h100, 32'h2, 5'd12, 1, 1, 0);
    flush = 1'b1;
    step();
    push("flush", M_ALL, 0, 0, 0, 0, 4'h0, 0, 0, 5'd0, 0, 0, 0);
    flush = 1'b0;
    stall = 1'b0;
    id_idle();

    // Reset while stalled clears everything
    id_set(1, 32'h300, 32'h5, 32'h6, 32'h7, 5'd1, 5'd2, 5'd3, 4'h4, 0, 0, 1, 0, 0);
    step();
    push("pre_rst", 8'h31, 1, 0, 0, 0, 4'h4, 32'h300, 0, 0, 0, 0, 0);
    stall = 1'b1;
    reset = 1'b1;
    step();
    push("rst_stall", M_ALL, 0, 0, 0, 0, 4'h0, 0, 0, 5'd0, 0, 0, 0);
    reset = 1'b0;
    stall = 1'b0;
    id_idle();

    for (int i = 0; i < 10 && q.size() > 0; i++) step();
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain pending %0d want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
